// File: rtl/alu_operand_stage.sv
// ID/EX operand register: selects ALU A/B/op from register reads and the instruction word,
// then holds them behind a 2-entry valid/ready skid buffer.
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [31:0]       in_instr,
  input  logic [OP_W-1:0]   in_alu_op,
  input  logic              in_is_shift,
  input  logic              in_alu_src,
  input  logic              in_zext,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [OP_W-1:0]   out_op,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   main_a_r, main_b_r, skid_a_r, skid_b_r;
  logic [OP_W-1:0]     main_op_r, skid_op_r;
  logic [CNT_W-1:0]    stall_cnt_r;
  logic [DATA_W-1:0]   new_a_s, new_b_s, imm_s;
  logic                accept_s, fire_s;

  // Extend the 16-bit immediate to operand width; shifts always sign-extend.
  function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm, input logic zext);
    if (zext) begin
      ext_imm = {{(DATA_W-16){1'b0}}, imm};
    end else begin
      ext_imm = {{(DATA_W-16){imm[15]}}, imm};
    end
  endfunction

  // Operand select for the beat currently presented upstream.
  always_comb begin
    imm_s   = ext_imm(in_instr[15:0], in_zext && !in_is_shift);
    new_a_s = in_rs_data;
    new_b_s = in_rt_data;
    if (in_is_shift) begin
      new_a_s = in_rt_data;
      new_b_s = imm_s;
    end else if (in_alu_src) begin
      new_b_s = imm_s;
    end else begin
      new_b_s = in_rt_data;
    end
  end

  assign in_ready  = (state_r != TWO);
  assign out_valid = (state_r != EMPTY);
  assign accept_s  = in_valid && in_ready;
  assign fire_s    = out_valid && out_ready;
  assign out_a     = main_a_r;
  assign out_b     = main_b_r;
  assign out_op    = main_op_r;
  assign stall_cnt = stall_cnt_r;

  // Skid-buffer FSM with main and skid data registers; flush wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= EMPTY;
      main_a_r  <= {DATA_W{1'b0}};
      main_b_r  <= {DATA_W{1'b0}};
      main_op_r <= {OP_W{1'b0}};
      skid_a_r  <= {DATA_W{1'b0}};
      skid_b_r  <= {DATA_W{1'b0}};
      skid_op_r <= {OP_W{1'b0}};
    end else if (flush) begin
      state_r <= EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_r   <= ONE;
            main_a_r  <= new_a_s;
            main_b_r  <= new_b_s;
            main_op_r <= in_alu_op;
          end
        end
        ONE: begin
          if (accept_s && fire_s) begin
            main_a_r  <= new_a_s;
            main_b_r  <= new_b_s;
            main_op_r <= in_alu_op;
          end else if (accept_s) begin
            state_r   <= TWO;
            skid_a_r  <= new_a_s;
            skid_b_r  <= new_b_s;
            skid_op_r <= in_alu_op;
          end else if (fire_s) begin
            state_r <= EMPTY;
          end
        end
        TWO: begin
          if (fire_s) begin
            state_r   <= ONE;
            main_a_r  <= skid_a_r;
            main_b_r  <= skid_b_r;
            main_op_r <= skid_op_r;
          end
        end
        default: state_r <= EMPTY;
      endcase
    end
  end

  // Saturating count of stalled cycles; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (out_valid && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: operand select, skid backpressure, flush, streaming, reset.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] in_rs_data, in_rt_data, in_instr;
  logic [2:0]  in_alu_op;
  logic        in_is_shift, in_alu_src, in_zext;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic [2:0]  out_op;
  logic [15:0] stall_cnt;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] srl_res;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_instr(in_instr),
    .in_alu_op(in_alu_op), .in_is_shift(in_is_shift), .in_alu_src(in_alu_src),
    .in_zext(in_zext), .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
    .out_b(out_b), .out_op(out_op), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] instr,
                      input logic [2:0] op, input logic sh, input logic src, input logic zx);
    in_valid    = 1'b1;
    in_rs_data  = rs;
    in_rt_data  = rt;
    in_instr    = instr;
    in_alu_op   = op;
    in_is_shift = sh;
    in_alu_src  = src;
    in_zext     = zx;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    beat(32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // srl with shamt 2
    out_ready = 1'b1;
    beat(32'hDEADBEEF, 32'h80000000, 32'h00041082, 3'd5, 1'b1, 1'b0, 1'b0);
    tick();
    chk("srl_valid", {31'd0, out_valid}, 32'd1);
    chk("srl_a", out_a, 32'h80000000);
    chk("srl_b", out_b, 32'h00001082);
    chk("srl_op", {29'd0, out_op}, 32'd5);
    srl_res = out_a >> out_b[10:6];
    chk("srl_result", srl_res, 32'h20000000);

    // shift ignores zext
    beat(32'h0, 32'h00000001, 32'h0000F0C0, 3'd6, 1'b1, 1'b0, 1'b1);
    tick();
    chk("shift_zext_ignored_b", out_b, 32'hFFFFF0C0);

    // immediate variants
    beat(32'h11111111, 32'h22222222, 32'h2001FFFC, 3'd2, 1'b0, 1'b1, 1'b0);
    tick();
    chk("imm_sext_a", out_a, 32'h11111111);
    chk("imm_sext_b", out_b, 32'hFFFFFFFC);
    beat(32'h11111111, 32'h22222222, 32'h2001FFFC, 3'd1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("imm_zext_b", out_b, 32'h0000FFFC);
    beat(32'h33333333, 32'h12345678, 32'h2001FFFC, 3'd2, 1'b0, 1'b0, 1'b0);
    tick();
    chk("reg_b", out_b, 32'h12345678);
    chk("reg_a", out_a, 32'h33333333);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("nostall_cnt", {16'd0, stall_cnt}, 32'd0);

    // backpressure D0,D1,D2
    out_ready = 1'b0;
    beat(32'hD0D0D0D0, 32'h0000D0B0, 32'h0, 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_d0_a", out_a, 32'hD0D0D0D0);
    chk("bp_ready1", {31'd0, in_ready}, 32'd1);
    chk("bp_stall0", {16'd0, stall_cnt}, 32'd0);
    beat(32'hD1D1D1D1, 32'h0000D1B1, 32'h0, 3'd2, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_full", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_d0", out_a, 32'hD0D0D0D0);
    chk("bp_stall1", {16'd0, stall_cnt}, 32'd1);
    beat(32'hD2D2D2D2, 32'h0000D2B2, 32'h0, 3'd3, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_still_full", {31'd0, in_ready}, 32'd0);
    chk("bp_stall2", {16'd0, stall_cnt}, 32'd2);
    tick();
    chk("bp_stall3", {16'd0, stall_cnt}, 32'd3);
    chk("bp_d0_b", out_b, 32'h0000D0B0);
    out_ready = 1'b1;
    tick();
    chk("bp_d1_a", out_a, 32'hD1D1D1D1);
    chk("bp_d1_op", {29'd0, out_op}, 32'd2);
    chk("bp_ready_again", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_d2_a", out_a, 32'hD2D2D2D2);
    chk("bp_d2_b", out_b, 32'h0000D2B2);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    chk("bp_stall_final", {16'd0, stall_cnt}, 32'd3);

    // flush while full
    out_ready = 1'b0;
    beat(32'hE0E0E0E0, 32'h0, 32'h0, 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    beat(32'hE1E1E1E1, 32'h0, 32'h0, 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fl_full", {31'd0, in_ready}, 32'd0);
    chk("fl_stall_pre", {16'd0, stall_cnt}, 32'd4);
    beat(32'hE2E2E2E2, 32'h0, 32'h0, 3'd1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_stall", {16'd0, stall_cnt}, 32'd4);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("fl_dropped", {31'd0, out_valid}, 32'd0);

    // 8-beat stream
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat(32'hA0000000 + i, 32'hB0000000 + i, 32'h0, 3'd4, 1'b0, 1'b0, 1'b0);
      tick();
      chk("st_valid", {31'd0, out_valid}, 32'd1);
      chk("st_ready", {31'd0, in_ready}, 32'd1);
      chk("st_a", out_a, 32'hA0000000 + i);
      chk("st_b", out_b, 32'hB0000000 + i);
    end
    in_valid = 1'b0;
    tick();
    chk("st_end", {31'd0, out_valid}, 32'd0);
    chk("st_stall", {16'd0, stall_cnt}, 32'd4);

    // async reset while full
    out_ready = 1'b0;
    beat(32'hF0F0F0F0, 32'h1, 32'h0, 3'd7, 1'b0, 1'b0, 1'b0);
    tick();
    beat(32'hF1F1F1F1, 32'h2, 32'h0, 3'd7, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ar_full", {31'd0, in_ready}, 32'd0);
    chk("ar_stall_pre", {16'd0, stall_cnt}, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_ready", {31'd0, in_ready}, 32'd1);
    chk("ar_a", out_a, 32'd0);
    chk("ar_op", {29'd0, out_op}, 32'd0);
    chk("ar_stall", {16'd0, stall_cnt}, 32'd0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_after", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
